// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pipe_pkg
// Brief   : Shared pipeline widths, ALUOp encodings and the control bundle
//           carried through ID/EX and EX/MEM.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int c_xlen   = 64;
    localparam int c_reg_aw = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,  // loads, stores, address add
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_write;
        logic   mem_to_reg;
        logic   mem_read;
        logic   mem_write;
        logic   branch;
        logic   alu_src;
        aluop_e alu_op;
    } ctrl_t;

    localparam ctrl_t c_ctrl_bubble = ctrl_t'('0);

endpackage : riscv_pipe_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Brief   : Combinational load-use hazard check between a load in a later
//           stage and the instruction currently in ID.
// Revision: 1.0 - initial release
// ============================================================================
module load_use_detect
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = c_reg_aw
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    output logic              o_hazard
);

    logic w_load_live;
    logic w_rs1_match;
    logic w_rs2_match;

    // x0 is never a real producer, so a load targeting it cannot stall
    assign w_load_live = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
    assign w_rs1_match = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_match = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_hazard    = w_load_live & i_id_valid & (w_rs1_match | w_rs2_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/idex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : idex_stage_reg
// Brief   : ID/EX pipeline register with load-use stall and flush bubbles.
//           Optional stall/flush counters when IDEX_STALL_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module idex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = c_xlen,
    parameter int REG_AW = c_reg_aw
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              id_ALUSrc,
    input  logic [1:0]        id_ALUOp,
    input  logic              flush,
    output logic              stall,
    output logic              IDEX_valid,
    output logic [XLEN-1:0]   IDEX_pc,
    output logic [XLEN-1:0]   IDEX_rs1_data,
    output logic [XLEN-1:0]   IDEX_rs2_data,
    output logic [XLEN-1:0]   IDEX_imm,
    output logic [REG_AW-1:0] IDEX_rs1,
    output logic [REG_AW-1:0] IDEX_rs2,
    output logic [REG_AW-1:0] IDEX_rd,
    output logic              IDEX_RegWrite,
    output logic              IDEX_MemtoReg,
    output logic              IDEX_MemRead,
    output logic              IDEX_MemWrite,
    output logic              IDEX_Branch,
    output logic              IDEX_ALUSrc,
    output logic [1:0]        IDEX_ALUOp
`ifdef IDEX_STALL_STATS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    ctrl_t             r_ctrl;

    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    ctrl_t             w_id_ctrl;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .o_hazard      (w_hazard)
    );

    // A flush already kills the ID instruction, so holding it would be wasted
    assign w_stall  = w_hazard & ~flush;
    assign w_bubble = flush | w_stall | ~id_valid;

    assign w_id_ctrl = '{
        reg_write:  id_RegWrite,
        mem_to_reg: id_MemtoReg,
        mem_read:   id_MemRead,
        mem_write:  id_MemWrite,
        branch:     id_Branch,
        alu_src:    id_ALUSrc,
        alu_op:     aluop_e'(id_ALUOp)
    };

    // Bubbles zero every field so rd=0 can never match in forwarding
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= c_ctrl_bubble;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_ctrl     <= w_id_ctrl;
        end
    end

`ifdef IDEX_STALL_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

    assign stall         = w_stall;
    assign IDEX_valid    = r_valid;
    assign IDEX_pc       = r_pc;
    assign IDEX_rs1_data = r_rs1_data;
    assign IDEX_rs2_data = r_rs2_data;
    assign IDEX_imm      = r_imm;
    assign IDEX_rs1      = r_rs1;
    assign IDEX_rs2      = r_rs2;
    assign IDEX_rd       = r_rd;
    assign IDEX_RegWrite = r_ctrl.reg_write;
    assign IDEX_MemtoReg = r_ctrl.mem_to_reg;
    assign IDEX_MemRead  = r_ctrl.mem_read;
    assign IDEX_MemWrite = r_ctrl.mem_write;
    assign IDEX_Branch   = r_ctrl.branch;
    assign IDEX_ALUSrc   = r_ctrl.alu_src;
    assign IDEX_ALUOp    = r_ctrl.alu_op;

endmodule : idex_stage_reg
`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_idex_stage_reg
// Brief   : Self-checking bench for idex_stage_reg: directed hazard scenarios
//           followed by randomized instruction streams against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_idex_stage_reg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2;
    logic              id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc;
    logic [1:0]        id_ALUOp;
    logic              flush;
    logic              stall;
    logic              IDEX_valid;
    logic [XLEN-1:0]   IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
    logic [REG_AW-1:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic              IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc;
    logic [1:0]        IDEX_ALUOp;
`ifdef IDEX_STALL_STATS_EN
    logic [31:0]       stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    idex_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
        .id_ALUOp(id_ALUOp), .flush(flush), .stall(stall), .IDEX_valid(IDEX_valid),
        .IDEX_pc(IDEX_pc), .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data),
        .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemWrite(IDEX_MemWrite), .IDEX_Branch(IDEX_Branch), .IDEX_ALUSrc(IDEX_ALUSrc),
        .IDEX_ALUOp(IDEX_ALUOp)
`ifdef IDEX_STALL_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // Reference view of what EX should hold after each edge
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc, rs1d, rs2d, imm;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic              rw, m2r, mr, mw, br, as;
        logic [1:0]        op;
    } ex_t;

    ex_t m_ex;
    int  m_stalls;
    int  m_flushes;
    bit  last_stall;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [279:0] obs, input logic [279:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t dut_view();
        return {IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
                IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_RegWrite, IDEX_MemtoReg,
                IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc, IDEX_ALUOp};
    endfunction

    // A valid load in EX writing a nonzero register read by a valid ID instruction stalls, unless flushed
    function automatic bit model_stall();
        bit reads_rd;
        reads_rd = (id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd);
        return m_ex.valid && m_ex.mr && (m_ex.rd != 0) && id_valid && reads_rd && !flush;
    endfunction

    task automatic cycle(input string tag);
        bit st;
        #1;
        st = model_stall();
        check({tag, "_stall"}, 280'(stall), 280'(st));
        @(posedge clk);
        if (reset) begin
            m_ex = '0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (st) m_stalls++;
            if (flush) m_flushes++;
            if (flush || st || !id_valid) m_ex = '0;
            else m_ex = '{valid: 1'b1, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data,
                          imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                          rw: id_RegWrite, m2r: id_MemtoReg, mr: id_MemRead,
                          mw: id_MemWrite, br: id_Branch, as: id_ALUSrc, op: id_ALUOp};
        end
        last_stall = st;
        #1;
        check({tag, "_ex"}, dut_view(), m_ex);
`ifdef IDEX_STALL_STATS_EN
        check({tag, "_scnt"}, 280'(stall_count), 280'(m_stalls));
        check({tag, "_fcnt"}, 280'(flush_count), 280'(m_flushes));
`endif
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_RegWrite = 0; id_MemtoReg = 0; id_MemRead = 0; id_MemWrite = 0;
        id_Branch = 0; id_ALUSrc = 0; id_ALUOp = 2'b00; flush = 0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic [63:0] pc);
        clear_id();
        id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_uses_rs1 = 1;
        id_imm = 64'h8; id_rs1_data = {$urandom, $urandom};
        id_RegWrite = 1; id_MemtoReg = 1; id_MemRead = 1; id_ALUSrc = 1; id_ALUOp = 2'b00;
    endtask

    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [63:0] pc);
        clear_id();
        id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_RegWrite = 1; id_ALUOp = 2'b10;
        id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
    endtask

    task automatic rand_id();
        id_valid    = ($urandom_range(0, 7) != 0);
        id_pc       = {$urandom, $urandom};
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 3));
        id_uses_rs1 = 1'($urandom);
        id_uses_rs2 = 1'($urandom);
        id_RegWrite = 1'($urandom);
        id_MemtoReg = 1'($urandom);
        id_MemRead  = 1'($urandom);
        id_MemWrite = 1'($urandom);
        id_Branch   = 1'($urandom);
        id_ALUSrc   = 1'($urandom);
        id_ALUOp    = 2'($urandom);
    endtask

    initial begin
        m_ex = '0; m_stalls = 0; m_flushes = 0; last_stall = 0;
        clear_id();
        reset = 1; id_valid = 1; id_RegWrite = 1;
        @(posedge clk);
        #1;
        cycle("reset1");
        cycle("reset2");
        reset = 0;

        clear_id();
        id_valid = 1; id_pc = 64'h100; id_rd = 5; id_RegWrite = 1; id_imm = 64'h10;
        cycle("capture");

        load(5, 2, 64'h200);
        cycle("ld_x5");
        rtype(6, 5, 7, 1, 1, 64'h204);
        cycle("lu_stall");
        cycle("lu_resume");

        load(5, 2, 64'h300);
        cycle("ld_x5_b");
        rtype(6, 1, 5, 1, 0, 64'h304);
        cycle("rs2_unused");

        load(0, 2, 64'h400);
        cycle("ld_x0");
        rtype(6, 0, 0, 1, 1, 64'h404);
        cycle("x0_nostall");

        load(5, 2, 64'h500);
        cycle("ld_x5_c");
        rtype(6, 5, 5, 1, 1, 64'h504);
        flush = 1;
        cycle("flush_prio");

        load(5, 2, 64'h600);
        cycle("b2b_ld1");
        load(6, 5, 64'h604);
        cycle("b2b_stall1");
        cycle("b2b_ld2");
        rtype(7, 6, 1, 1, 1, 64'h608);
        cycle("b2b_stall2");
        cycle("b2b_add");

        load(5, 2, 64'h700);
        cycle("ld_x5_d");
        rtype(6, 5, 7, 1, 1, 64'h704);
        reset = 1;
        cycle("rst_mid_stall");
        cycle("rst_after");
        reset = 0;
        cycle("rst_release");

        for (int i = 0; i < 400; i++) begin
            if (!last_stall) rand_id();
            flush = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        reset = 1;
        cycle("final_reset");
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_idex_stage_reg
`default_nettype wire
